// File: rtl/ddr3_wr_pkg.sv
// Shared tags, FSM encoding and burst geometry for the DDR3 write path.
// Tag values identify the content of each 132-bit FIFO word.
package ddr3_wr_pkg;

    localparam int TAG_W        = 4;
    localparam int PAYLOAD_W    = 128;
    localparam int WORD_W       = TAG_W + PAYLOAD_W;
    localparam int CNT_W        = 24;
    localparam int BURST_STRIDE = 8;

    localparam logic [TAG_W-1:0] TAG_DATA     = 4'h0;
    localparam logic [TAG_W-1:0] TAG_FILL_HDR = 4'h1;
    localparam logic [TAG_W-1:0] TAG_WFM_HDR  = 4'h2;
    localparam logic [TAG_W-1:0] TAG_TRAILER  = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [PAYLOAD_W-1:0] payload;
    } fifo_word_t;

    function automatic logic tag_known(input logic [TAG_W-1:0] tag);
        return (tag == TAG_DATA) || (tag == TAG_FILL_HDR) ||
               (tag == TAG_WFM_HDR) || (tag == TAG_TRAILER);
    endfunction

endpackage

// File: rtl/ddr3_burst_addr_gen.sv
// Burst address generator: wrapping 8-byte-stride address, fill start latch, saturating burst count.
// Updates one cycle after advance_i/fill_start_i; no backpressure of its own.
module ddr3_burst_addr_gen
    import ddr3_wr_pkg::*;
#(
    parameter int          ADDR_W     = 26,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MEM_BURSTS = 2**23
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              fill_start_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] fill_start_adr_o,
    output logic [CNT_W-1:0]  burst_count_o
);

    localparam logic [63:0]       LAST_L    = 64'(BASE_ADDR) + (64'(MEM_BURSTS) - 64'd1) * 64'(BURST_STRIDE);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = LAST_L[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BURST_STRIDE);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fsa_q, fsa_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        fsa_d  = fsa_q;
        cnt_d  = cnt_q;
        if (fill_start_i) begin
            fsa_d = addr_q;
            cnt_d = '0;
        end
        if (advance_i) begin
            addr_d = (addr_q == LAST_ADDR) ? BASE : addr_q + STRIDE;
            // Saturate so a runaway fill never reports a small count.
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= BASE;
            fsa_q  <= BASE;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            fsa_q  <= fsa_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o           = addr_q;
    assign fill_start_adr_o = fsa_q;
    assign burst_count_o    = cnt_q;

endmodule

// File: rtl/ddr3_wr_control.sv
// Drains tagged FIFO words into single-beat DDR3 write bursts; pop to app_en 1 cycle, >=2 cycles/burst.
// Backpressure: app_en / app_wdf_wren each hold until their own ready; next pop waits for both.
module ddr3_wr_control
    import ddr3_wr_pkg::*;
#(
    parameter int          ADDR_W     = 26,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MEM_BURSTS = 2**23
) (
    input  logic                 clk200,
    input  logic                 reset_clk200_n,
    input  logic                 ddr3_wr_en,
    input  logic [WORD_W-1:0]    fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 app_en,
    output logic [2:0]           app_cmd,
    output logic [ADDR_W-1:0]    app_addr,
    input  logic                 app_rdy,
    output logic [PAYLOAD_W-1:0] app_wdf_data,
    output logic                 app_wdf_wren,
    output logic                 app_wdf_end,
    input  logic                 app_wdf_rdy,
    output logic                 ddr3_wr_done,
    output logic [ADDR_W-1:0]    fill_start_adr,
    output logic [CNT_W-1:0]     total_burst_count,
    output logic                 tag_error
);

    state_e               state_q, state_d;
    logic                 cmd_vld_q, cmd_vld_d;
    logic                 dat_vld_q, dat_vld_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 first_q, first_d;
    logic                 abort_q, abort_d;
    logic                 tag_err_q, tag_err_d;

    fifo_word_t head;
    logic       pop;
    logic       cmd_done;
    logic       dat_done;
    logic       burst_done;
    logic       start_fill;

    assign head       = fifo_dout;
    assign cmd_done   = !cmd_vld_q || app_rdy;
    assign dat_done   = !dat_vld_q || app_wdf_rdy;
    assign burst_done = (state_q == WRITE) && cmd_done && dat_done;
    assign start_fill = pop && first_q;

    always_ff @(posedge clk200 or negedge reset_clk200_n) begin
        if (!reset_clk200_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ddr3_wr_en) state_d = WAIT;
            end
            WAIT: begin
                if (!ddr3_wr_en)      state_d = IDLE;
                else if (!fifo_empty) state_d = WRITE;
            end
            WRITE: begin
                // A disable seen at any point during the burst wins over the trailer.
                if (burst_done) begin
                    if (abort_q || !ddr3_wr_en)     state_d = IDLE;
                    else if (tag_q == TAG_TRAILER) state_d = DONE;
                    else                           state_d = WAIT;
                end
            end
            DONE: begin
                if (!ddr3_wr_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop          = (state_q == WAIT) && ddr3_wr_en && !fifo_empty;
        fifo_rd_en   = pop;
        ddr3_wr_done = (state_q == DONE);
    end

    always_comb begin
        cmd_vld_d = cmd_vld_q;
        dat_vld_d = dat_vld_q;
        data_d    = data_q;
        tag_d     = tag_q;
        first_d   = first_q;
        abort_d   = abort_q;
        tag_err_d = tag_err_q;
        if (pop) begin
            cmd_vld_d = 1'b1;
            dat_vld_d = 1'b1;
            data_d    = head.payload;
            tag_d     = head.tag;
            first_d   = 1'b0;
            if ((first_q && head.tag != TAG_FILL_HDR) || !tag_known(head.tag)) begin
                tag_err_d = 1'b1;
            end
        end
        if (cmd_vld_q && app_rdy)     cmd_vld_d = 1'b0;
        if (dat_vld_q && app_wdf_rdy) dat_vld_d = 1'b0;
        if (state_q == WRITE && !ddr3_wr_en) abort_d = 1'b1;
        if (state_d == IDLE) begin
            first_d = 1'b1;
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge clk200 or negedge reset_clk200_n) begin
        if (!reset_clk200_n) begin
            cmd_vld_q <= 1'b0;
            dat_vld_q <= 1'b0;
            data_q    <= '0;
            tag_q     <= '0;
            first_q   <= 1'b1;
            abort_q   <= 1'b0;
            tag_err_q <= 1'b0;
        end else begin
            cmd_vld_q <= cmd_vld_d;
            dat_vld_q <= dat_vld_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            first_q   <= first_d;
            abort_q   <= abort_d;
            tag_err_q <= tag_err_d;
        end
    end

    ddr3_burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .MEM_BURSTS (MEM_BURSTS)
    ) u_addr_gen (
        .clk_i            (clk200),
        .rst_n_i          (reset_clk200_n),
        .fill_start_i     (start_fill),
        .advance_i        (burst_done),
        .addr_o           (app_addr),
        .fill_start_adr_o (fill_start_adr),
        .burst_count_o    (total_burst_count)
    );

    assign app_en       = cmd_vld_q;
    assign app_cmd      = 3'b000;
    assign app_wdf_data = data_q;
    assign app_wdf_wren = dat_vld_q;
    assign app_wdf_end  = dat_vld_q;
    assign tag_error    = tag_err_q;

endmodule

// File: tb/tb_ddr3_wr_control.sv
// Scoreboard bench: two instances share stimulus, one with default region size and one with a 4-burst region.
module tb_ddr3_wr_control;
    import ddr3_wr_pkg::*;

    logic clk200 = 1'b0;
    always #5 clk200 = ~clk200;

    logic         rst_n;
    logic         en;
    logic [131:0] fifo_dout  = '0;
    logic         fifo_empty = 1'b1;
    logic         app_rdy;
    logic         app_wdf_rdy;

    logic         a_rd, a_en, a_wren, a_end, a_done, a_terr;
    logic [2:0]   a_cmd;
    logic [25:0]  a_addr, a_fsa;
    logic [127:0] a_data;
    logic [23:0]  a_cnt;

    logic         b_rd, b_en, b_wren, b_end, b_done, b_terr;
    logic [2:0]   b_cmd;
    logic [25:0]  b_addr, b_fsa;
    logic [127:0] b_data;
    logic [23:0]  b_cnt;

    ddr3_wr_control dut_a (
        .clk200(clk200), .reset_clk200_n(rst_n), .ddr3_wr_en(en),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(a_rd),
        .app_en(a_en), .app_cmd(a_cmd), .app_addr(a_addr), .app_rdy(app_rdy),
        .app_wdf_data(a_data), .app_wdf_wren(a_wren), .app_wdf_end(a_end),
        .app_wdf_rdy(app_wdf_rdy), .ddr3_wr_done(a_done), .fill_start_adr(a_fsa),
        .total_burst_count(a_cnt), .tag_error(a_terr)
    );

    ddr3_wr_control #(.MEM_BURSTS(4)) dut_b (
        .clk200(clk200), .reset_clk200_n(rst_n), .ddr3_wr_en(en),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(b_rd),
        .app_en(b_en), .app_cmd(b_cmd), .app_addr(b_addr), .app_rdy(app_rdy),
        .app_wdf_data(b_data), .app_wdf_wren(b_wren), .app_wdf_end(b_end),
        .app_wdf_rdy(app_wdf_rdy), .ddr3_wr_done(b_done), .fill_start_adr(b_fsa),
        .total_burst_count(b_cnt), .tag_error(b_terr)
    );

    int total = 0;
    int bad   = 0;

    logic [131:0] fq[$];
    logic [25:0]  exp_a[$];
    logic [25:0]  exp_b[$];
    logic [127:0] exp_d[$];
    logic         pop_now = 1'b0;
    logic [131:0] popped;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [127:0] pl(input int i);
        return {32'hC0DE_0000 | 32'(i), ~32'(i), 32'(i * 3), 32'hFACE_0000 + 32'(i)};
    endfunction

    task automatic issue(input logic [3:0] tag, input int idx, input logic [25:0] ea, input logic [25:0] eb);
        fq.push_back({tag, pl(idx)});
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        exp_d.push_back(pl(idx));
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!a_done && n < 200) begin
            @(negedge clk200); #3;
            n++;
        end
        chk(nm, a_done, 1'b1);
    endtask

    task automatic wait_app_en(input string nm);
        int n = 0;
        while (!a_en && n < 50) begin
            @(negedge clk200); #3;
            n++;
        end
        chk(nm, a_en, 1'b1);
    endtask

    // FWFT FIFO model; head/empty change only on the clock edge.
    always @(posedge clk200) begin
        if (pop_now && fq.size() > 0) popped = fq.pop_front();
        fifo_dout  <= (fq.size() > 0) ? fq[0] : '0;
        fifo_empty <= (fq.size() == 0);
    end

    // Monitor: handshakes are judged mid-cycle, ahead of the edge that completes them.
    always begin
        @(negedge clk200); #2;
        pop_now = a_rd;
        if (a_en && app_rdy) begin
            chk("cmd_expected", exp_a.size() > 0, 1'b1);
            if (exp_a.size() > 0) begin
                chk("cmd_addr_a", a_addr, exp_a.pop_front());
                chk("cmd_addr_b", b_addr, exp_b.pop_front());
                chk("app_cmd", a_cmd, 3'b000);
                chk("b_app_en", b_en, 1'b1);
            end
        end
        if (a_wren && app_wdf_rdy) begin
            chk("dat_expected", exp_d.size() > 0, 1'b1);
            if (exp_d.size() > 0) begin
                chk("wdf_data", a_data, exp_d.pop_front());
                chk("wdf_end", a_end, 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        #3;
        chk("rst_app_en", a_en, 1'b0);
        chk("rst_wren", a_wren, 1'b0);
        chk("rst_rd_en", a_rd, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_addr", a_addr, 26'd0);
        chk("rst_fsa", a_fsa, 26'd0);
        chk("rst_cnt", a_cnt, 24'd0);
        chk("rst_tag_err", a_terr, 1'b0);
        repeat (2) @(negedge clk200);
        rst_n = 1'b1;

        // Fill 1: six words, region of 4 wraps on instance B
        @(negedge clk200);
        en = 1'b1;
        issue(TAG_FILL_HDR, 0,  0, 0);
        issue(TAG_WFM_HDR,  1,  8, 8);
        issue(TAG_DATA,     2, 16, 16);
        issue(TAG_DATA,     3, 24, 24);
        issue(TAG_DATA,     4, 32, 0);
        issue(TAG_TRAILER,  5, 40, 8);
        wait_done("t1_done");
        chk("t1_cnt", a_cnt, 24'd6);
        chk("t1_fsa", a_fsa, 26'd0);
        chk("t1_next_addr", a_addr, 26'd48);
        chk("t1_b_next_addr", b_addr, 26'd16);
        chk("t1_tag_err", a_terr, 1'b0);

        // Fill 2: done clears one cycle after disable
        @(negedge clk200);
        en = 1'b0;
        #3 chk("t2_done_hold", a_done, 1'b1);
        @(negedge clk200); #3;
        chk("t2_done_clear", a_done, 1'b0);
        @(negedge clk200);
        en = 1'b1;
        issue(TAG_FILL_HDR, 6, 48, 16);
        issue(TAG_TRAILER,  7, 56, 24);
        wait_done("t2_done");
        chk("t2_fsa", a_fsa, 26'd48);
        chk("t2_cnt", a_cnt, 24'd2);
        chk("t2_b_fsa", b_fsa, 26'd16);

        // Fill 3: command stalled, data accepted first
        @(negedge clk200); en = 1'b0;
        @(negedge clk200); en = 1'b1; app_rdy = 1'b0;
        issue(TAG_FILL_HDR, 8, 64, 0);
        wait_app_en("t3_app_en");
        chk("t3_wren_first", a_wren, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk200); #3;
            chk("t3_en_held", a_en, 1'b1);
            chk("t3_addr_stable", a_addr, 26'd64);
            chk("t3_data_taken", a_wren, 1'b0);
        end
        @(negedge clk200); app_rdy = 1'b1;
        @(negedge clk200); #3;
        chk("t3_en_drop", a_en, 1'b0);
        chk("t3_one_incr", a_addr, 26'd72);
        chk("t3_cnt", a_cnt, 24'd1);
        issue(TAG_TRAILER, 9, 72, 8);
        wait_done("t3_done");
        chk("t3_cnt_end", a_cnt, 24'd2);
        chk("t3_fsa", a_fsa, 26'd64);

        // Fill 4: bad first tag is flagged but still written
        @(negedge clk200); en = 1'b0;
        @(negedge clk200); en = 1'b1;
        issue(4'h5, 10, 80, 16);
        issue(TAG_TRAILER, 11, 88, 24);
        wait_done("t5_done");
        chk("t5_tag_err", a_terr, 1'b1);
        chk("t5_cnt", a_cnt, 24'd2);
        @(negedge clk200); en = 1'b0;
        @(negedge clk200); #3;
        chk("t5_tag_err_sticky", a_terr, 1'b1);

        // Async reset while a burst is stalled in WRITE
        @(negedge clk200);
        en = 1'b1; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        issue(TAG_FILL_HDR, 12, 96, 0);
        wait_app_en("t6_app_en");
        #1 rst_n = 1'b0;
        #1;
        chk("t6_app_en_async", a_en, 1'b0);
        chk("t6_wren_async", a_wren, 1'b0);
        chk("t6_rd_en_async", a_rd, 1'b0);
        chk("t6_b_app_en_async", b_en, 1'b0);
        chk("t6_pending", exp_a.size(), 1);
        exp_a.delete(); exp_b.delete(); exp_d.delete();
        en = 1'b0;
        @(negedge clk200); app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        @(negedge clk200); rst_n = 1'b1;
        #3;
        chk("t6_addr", a_addr, 26'd0);
        chk("t6_fsa", a_fsa, 26'd0);
        chk("t6_cnt", a_cnt, 24'd0);
        chk("t6_tag_err_clr", a_terr, 1'b0);
        chk("t6_state", dut_a.state_q, IDLE);
        chk("t6_fifo_not_rewound", fq.size(), 0);

        @(negedge clk200); en = 1'b1;
        issue(TAG_FILL_HDR, 13, 0, 0);
        issue(TAG_TRAILER,  14, 8, 8);
        wait_done("t6_refill_done");
        chk("t6_refill_cnt", a_cnt, 24'd2);
        @(negedge clk200); #3;
        chk("end_cmd_drained", exp_a.size(), 0);
        chk("end_dat_drained", exp_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr3_wr_control.md
Name: ddr3_wr_control

Overview:
Reader end of the acquisition-to-memory path. Pops 132-bit tagged words (4-bit tag plus 128-bit header, ADC data or checksum) from the DDR3 write FIFO that the acquisition controller fills. Issues one DDR3 write burst per word on a MIG-style application interface. Reports fill completion back to the acquisition enable logic through ddr3_wr_done.

Parameters:
ADDR_W, 26, DDR3 application byte-address width; 3 LSBs always 0 (8-beat bursts).
BASE_ADDR, 0, first burst address after reset.
MEM_BURSTS, 2**23, number of bursts in the memory region; the address wraps to BASE_ADDR after the last one.

Ports:
clk200  in  1  DDR3 user-interface clock.
reset_clk200_n  in  1  asynchronous, active-low reset.
ddr3_wr_en  in  1  writing of triggered events to memory is enabled.
fifo_dout  in  132  FIFO head word: [131:128] tag, [127:0] payload.
fifo_empty  in  1  FIFO has no word.
fifo_rd_en  out  1  pop strobe (first-word-fall-through FIFO).
app_en  out  1  command valid.
app_cmd  out  3  always 3'b000 (write).
app_addr  out  ADDR_W  burst byte address.
app_rdy  in  1  command accepted when app_en && app_rdy.
app_wdf_data  out  128  write data.
app_wdf_wren  out  1  write-data valid.
app_wdf_end  out  1  equals app_wdf_wren (single-beat bursts).
app_wdf_rdy  in  1  data accepted when app_wdf_wren && app_wdf_rdy.
ddr3_wr_done  out  1  asserted in DONE state.
fill_start_adr  out  ADDR_W  address of the current fill's first burst (the fill header).
total_burst_count  out  24  bursts written in the current fill, saturating.
tag_error  out  1  sticky; unexpected tag seen.

Behaviour:
- Reset: all outputs 0. fill_start_adr and app_addr = BASE_ADDR. State = IDLE.
- Tags (package constants):
  - TAG_DATA = 4'h0
  - TAG_FILL_HDR = 4'h1
  - TAG_WFM_HDR = 4'h2
  - TAG_TRAILER = 4'hF (checksum, last word of a fill)
  - any other value is an error.
- IDLE:
  - Go to WAIT when ddr3_wr_en = 1.
  - In IDLE the FIFO is never popped.
- WAIT:
  - If ddr3_wr_en = 0 → IDLE.
  - Otherwise, when !fifo_empty: latch fifo_dout into the cmd/data registers, pulse fifo_rd_en for 1 cycle, go to WRITE.
  - On the first word of a fill: latch fill_start_adr = app_addr and clear total_burst_count.
  - If the first word is not TAG_FILL_HDR: set tag_error and still write the word.
- WRITE:
  - Assert app_en and app_wdf_wren together in the cycle after the pop.
  - Command and data handshakes are independent. Each valid drops individually once accepted. Both may complete in the same cycle.
  - When both are accepted:
    - Advance app_addr by 8; at the region end wrap to BASE_ADDR.
    - Increment total_burst_count, saturating at 24'hFFFFFF.
    - If the word was TAG_TRAILER → DONE; otherwise → WAIT.
  - Latency: FIFO pop to app_en = 1 cycle. Minimum 2 cycles per burst. Max throughput is 1 burst per 2 cycles with ready signals held high.
- ddr3_wr_en negated while in WRITE: the in-flight burst completes, then → IDLE. ddr3_wr_done stays 0.
- DONE:
  - ddr3_wr_done = 1 and no pops.
  - Hold until ddr3_wr_en = 0, then → IDLE, ddr3_wr_done = 0 the next cycle.
  - The next fill starts at the address after the trailer.
- fifo_empty asserted in WAIT: stay in WAIT indefinitely. No timeout.
- Asynchronous reset mid-burst: outputs drop immediately. The partially accepted burst is abandoned and the FIFO is not rewound.
- tag_error is cleared only by reset.

Decomposition:
- Package ddr3_wr_pkg holds the TAG_* constants, the state enum (IDLE, WAIT, WRITE, DONE) and BURST_STRIDE = 8.
- One natural sub-module, ddr3_burst_addr_gen: address register, wrap logic and the saturating burst counter.

Test Plan:
1. Reset, then ddr3_wr_en=1 with FIFO words FILL_HDR, WFM_HDR, 3×DATA, TRAILER, app_rdy/app_wdf_rdy held high → 6 bursts at addresses 0, 8, …, 40; total_burst_count=6; ddr3_wr_done=1; fill_start_adr=0.
2. Drop ddr3_wr_en after test 1, then run a second 2-word fill (FILL_HDR, TRAILER) → ddr3_wr_done clears 1 cycle after the drop; new bursts at 48, 56; fill_start_adr=48.
3. app_rdy low for 5 cycles while app_wdf_rdy is high → data accepted first; app_en held with app_addr stable until app_rdy; exactly one address increment.
4. MEM_BURSTS=4, 6-word fill → addresses 0, 8, 16, 24, 0, 8.
5. First word tagged 4'h5 → tag_error=1 and sticky; the word is still written.
6. Drive reset_clk200_n low mid-WRITE → app_en, app_wdf_wren and fifo_rd_en go to 0 without waiting for a clock edge; after release app_addr=BASE_ADDR and state is IDLE.
